// File: rtl/dna_port_emu.sv
// Soft responder for the device-DNA READ/SHIFT/DIN/DOUT serial ID protocol, with a
// one-time-lockable programming port. Define DNA_EMU_ROLLOVER_EN to shift din into the LSB.
module dna_port_emu #(
    parameter int               DNA_W       = 57,
    parameter logic [DNA_W-1:0] DEFAULT_DNA = 57'h0DEADBEEFCAFE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             read,
    input  logic             shift,
    input  logic             din,
    output logic             dout,
    input  logic             prog_valid,
    output logic             prog_ready,
    input  logic [DNA_W-1:0] prog_dna,
    input  logic             prog_lock,
    output logic             locked,
    output logic             loaded,
    output logic [6:0]       shift_count,
    output logic             proto_err
);

    localparam logic [6:0] COUNT_MAX  = 7'd127;
    localparam logic [6:0] COUNT_FULL = 7'(DNA_W);

    logic [DNA_W-1:0] id_reg;
    logic [DNA_W-1:0] sr;
    logic             in_bit;
    logic             busy;
    logic             prog_accept;

`ifdef DNA_EMU_ROLLOVER_EN
    assign in_bit = din;
`else
    // Without rollover the serial input is ignored and zeros fill the register.
    logic unused_din;
    assign unused_din = din;
    assign in_bit     = 1'b0;
`endif

    // The ID may not change while a loaded readout is still in progress.
    assign busy        = loaded && (shift_count < COUNT_FULL);
    assign prog_ready  = !locked && !busy;
    assign prog_accept = prog_valid && prog_ready;
    assign dout        = sr[DNA_W-1];

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values; e.g. a read in the accept cycle still loads the old ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_reg      <= DEFAULT_DNA;
            sr          <= '0;
            locked      <= 1'b0;
            loaded      <= 1'b0;
            shift_count <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (prog_accept) begin
                id_reg <= prog_dna;
                if (prog_lock) begin
                    locked <= 1'b1;
                end
            end

            if (read) begin
                sr          <= id_reg;
                shift_count <= '0;
                loaded      <= 1'b1;
            end else if (shift) begin
                sr <= {sr[DNA_W-2:0], in_bit};
                if (shift_count != COUNT_MAX) begin
                    shift_count <= shift_count + 7'd1;
                end
            end

            if ((shift && !loaded) || (read && shift)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dna_port_emu.sv
// Directed self-checking bench for dna_port_emu; expected values are hand-derived constants.
// Honours DNA_EMU_ROLLOVER_EN when the design is built with it.
module tb_dna_port_emu;

    localparam logic [56:0] DEF_ID  = 57'h0DEADBEEFCAFE;
    localparam logic [56:0] ID_A    = 57'h123456789ABCD;
    localparam logic [56:0] ID_B    = 57'h0555555555555;
    localparam logic [56:0] ID_ONES = 57'h1FFFFFFFFFFFFFF;
`ifdef DNA_EMU_ROLLOVER_EN
    localparam bit ROLL = 1'b1;
`else
    localparam bit ROLL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read = 1'b0;
    logic        shift = 1'b0;
    logic        din_drv = 1'b0;
    logic        loop_en = 1'b0;
    logic        prog_valid = 1'b0;
    logic [56:0] prog_dna = '0;
    logic        prog_lock = 1'b0;
    logic        din;
    logic        dout;
    logic        prog_ready;
    logic        locked;
    logic        loaded;
    logic [6:0]  shift_count;
    logic        proto_err;

    int tests = 0;
    int fails = 0;

    assign din = loop_en ? dout : din_drv;

    dna_port_emu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read        (read),
        .shift       (shift),
        .din         (din),
        .dout        (dout),
        .prog_valid  (prog_valid),
        .prog_ready  (prog_ready),
        .prog_dna    (prog_dna),
        .prog_lock   (prog_lock),
        .locked      (locked),
        .loaded      (loaded),
        .shift_count (shift_count),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read, then shift 57 times, capturing dout before each shift edge.
    task automatic readout(input string tag, input logic [56:0] exp);
        logic [56:0] got;
        got   = '0;
        read  = 1'b1;
        step();
        read  = 1'b0;
        shift = 1'b1;
        for (int i = 0; i < 57; i++) begin
            got[56-i] = dout;
            step();
        end
        shift = 1'b0;
        check(tag, 128'(got), 128'(exp));
    endtask

    initial begin
        logic        early;
        logic [113:0] got2;

        // Reset state
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_dout", 128'(dout), 128'(0));
        check("rst_locked", 128'(locked), 128'(0));
        check("rst_loaded", 128'(loaded), 128'(0));
        check("rst_prog_ready", 128'(prog_ready), 128'(1));
        check("rst_proto_err", 128'(proto_err), 128'(0));
        check("rst_shift_count", 128'(shift_count), 128'(0));

        // Shift before any read is a protocol error
        shift = 1'b1;
        step();
        shift = 1'b0;
        check("early_shift_err", 128'(proto_err), 128'(1));
        check("early_shift_dout", 128'(dout), 128'(0));

        // Read and shift together: read wins, error stays set
        read  = 1'b1;
        shift = 1'b1;
        step();
        read  = 1'b0;
        shift = 1'b0;
        check("rdsh_count", 128'(shift_count), 128'(0));
        check("rdsh_loaded", 128'(loaded), 128'(1));
        check("rdsh_dout", 128'(dout), 128'(DEF_ID[56]));
        check("rdsh_err", 128'(proto_err), 128'(1));
        check("rdsh_busy", 128'(prog_ready), 128'(0));

        // Default ID readout with din held high
        din_drv = 1'b1;
        readout("default_id", DEF_ID);
        check("full_count", 128'(shift_count), 128'(57));
        check("full_ready", 128'(prog_ready), 128'(1));
        check("post57_dout", 128'(dout), 128'(ROLL));
        din_drv = 1'b0;
        shift   = 1'b1;
        repeat (70) step();
        check("sat_count", 128'(shift_count), 128'(127));
        step();
        shift = 1'b0;
        check("sat_hold", 128'(shift_count), 128'(127));

        // Unlocked programming
        prog_dna   = ID_A;
        prog_valid = 1'b1;
        check("progA_ready", 128'(prog_ready), 128'(1));
        step();
        prog_valid = 1'b0;
        check("progA_unlocked", 128'(locked), 128'(0));
        readout("progA_id", ID_A);

        // Programming request mid-readout waits for shift_count to reach 57
        read = 1'b1;
        step();
        read  = 1'b0;
        shift = 1'b1;
        repeat (10) step();
        check("mid_count", 128'(shift_count), 128'(10));
        check("mid_ready", 128'(prog_ready), 128'(0));
        prog_dna   = ID_B;
        prog_valid = 1'b1;
        early      = 1'b0;
        for (int i = 0; i < 47; i++) begin
            if (prog_ready) early = 1'b1;
            step();
        end
        shift = 1'b0;
        check("mid_no_early_ready", 128'(early), 128'(0));
        check("mid_ready_at57", 128'(prog_ready), 128'(1));
        step();
        prog_valid = 1'b0;
        readout("progB_id", ID_B);

        // Locking write, then an ignored write
        prog_dna   = ID_ONES;
        prog_lock  = 1'b1;
        prog_valid = 1'b1;
        step();
        prog_lock = 1'b0;
        prog_dna  = '0;
        check("lock_set", 128'(locked), 128'(1));
        check("lock_ready", 128'(prog_ready), 128'(0));
        repeat (3) step();
        prog_valid = 1'b0;
        readout("locked_id", ID_ONES);
        check("lock_sticky", 128'(locked), 128'(1));
        check("err_sticky", 128'(proto_err), 128'(1));

        // Asynchronous reset mid-readout
        read = 1'b1;
        step();
        read  = 1'b0;
        shift = 1'b1;
        repeat (5) step();
        shift = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_locked", 128'(locked), 128'(0));
        check("arst_count", 128'(shift_count), 128'(0));
        check("arst_dout", 128'(dout), 128'(0));
        check("arst_err", 128'(proto_err), 128'(0));
        step();
        rst_n = 1'b1;
        step();
        readout("arst_id", DEF_ID);

        // Loopback: 114 shifts recirculate the ID only when rollover is built in
        loop_en = 1'b1;
        got2    = '0;
        read    = 1'b1;
        step();
        read  = 1'b0;
        shift = 1'b1;
        for (int i = 0; i < 114; i++) begin
            got2[113-i] = dout;
            step();
        end
        shift   = 1'b0;
        loop_en = 1'b0;
        check("loopback", 128'(got2), 128'({DEF_ID, (ROLL ? DEF_ID : 57'h0)}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
